request_dispatcher: RTL and testbench
=====================================

# request_dispatcher

Registered 1-to-N demultiplexer that steers one accepted beat per cycle to the output lane selected by an index. Each lane has a one-entry holding register with an independent valid/ready handshake. It sits downstream of the scheduler's selection logic: the scheduler picks a winning value and its lane index, and this block delivers that value to the chosen per-lane consumer.

## Interface
Parameters:
- OUTPUTS, default 8: number of output lanes; must be a power of 2 and at least 2.
- DATA_SIZE, default 8: width of one beat in bits.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept the presented beat this cycle.
- in_index  input  $clog2(OUTPUTS)  destination lane of the presented beat.
- in_data  input  DATA_SIZE  presented beat.
- out_valid  output  OUTPUTS  per-lane bit: holding register full.
- out_ready  input  OUTPUTS  per-lane bit: consumer accepts this cycle.
- out_data  output  DATA_SIZE × [OUTPUTS] (unpacked array)  per-lane beat.
- out_count  output  16 × [OUTPUTS] (unpacked array)  per-lane delivered-beat count; present only with DISPATCHER_COUNT_EN.

## Operation
- Per-lane state: `full[i]`, `data[i]`. out_valid[i] = full[i]. out_data[i] = data[i] when full[i], otherwise all zeros.
- in_ready = !full[in_index] || out_ready[in_index].
  - Combinational from lane state and the indexed out_ready only.
  - Never depends on in_valid.
- Accept: in_valid && in_ready. Load data[in_index] <= in_data and set full[in_index] <= 1.
- Deliver on lane i: out_valid[i] && out_ready[i]. Clear full[i], unless the same edge loads lane i.
- Simultaneous deliver and accept on the same lane: data is replaced and full stays 1. The lane supports 1 beat/cycle throughput.
- Accept on lane j while lane i≠j delivers: the two updates are independent.
- At most one lane is loaded per cycle. All lanes may deliver in the same cycle.
- Lanes with full=0 ignore out_ready.
- Out-of-range indices cannot occur: in_index width is exactly $clog2(OUTPUTS).
- Reset asserted mid-operation: all held beats are discarded and are not delivered.

## Timing
- Reset values:
  - out_valid = 0.
  - out_data = 0 on every lane.
  - out_count = 0 on every lane.
  - in_ready = 1, since all lanes are empty.
- Latency: a beat accepted at edge N is visible on out_valid and out_data from edge N.
- in_data to in_ready has no path. in_index and out_ready have a combinational path to in_ready.
- Once asserted, out_valid[i] and out_data[i] stay stable until lane i delivers.

## Configuration
- DISPATCHER_COUNT_EN defined:
  - out_count[i] is a 16-bit counter that increments on every delivery on lane i.
  - It saturates at 0xFFFF and never wraps.
  - It clears only on reset.
- DISPATCHER_COUNT_EN undefined: the out_count port and all counter logic are absent. Handshake behaviour is identical in both builds.

## Test plan
- Reset, then in_index=3, in_data=0xA5, in_valid for 1 cycle, all out_ready=0. Expected: out_valid=8'b0000_1000, out_data[3]=0xA5, all other lanes 0x00.
- Lane 3 full with out_ready[3]=0; present in_index=3. Expected: in_ready=0, and lane 3 keeps 0xA5 for 5 cycles. Present in_index=2 in the same state. Expected: in_ready=1, and lane 2 receives the beat.
- Lane 5 full with 0x11, out_ready[5]=1, accept 0x22 to lane 5 on the same edge. Expected: out_valid[5] stays 1, out_data[5]=0x22, and 0x11 is counted as delivered.
- Stream 8 beats with in_index=0..7 and all out_ready=1. Expected: in_ready=1 every cycle, and each lane shows its beat exactly one cycle.
- Assert reset while lanes 1 and 6 are full. Expected: out_valid=0, out_data all zero, out_count all 0 immediately, with no clock edge required.
- With DISPATCHER_COUNT_EN, deliver 70000 beats on lane 0. Expected: out_count[0]=0xFFFF and other lanes 0. Without the macro, the same stream gives identical out_valid and out_data.

Source files
------------

// File: rtl/request_dispatcher.sv
// Registered 1-to-N demux: one beat per cycle into a per-lane holding register.
// Optional per-lane delivered-beat counters under DISPATCHER_COUNT_EN.
module request_dispatcher #(
  parameter int OUTPUTS   = 8,
  parameter int DATA_SIZE = 8,
  localparam int IW       = $clog2(OUTPUTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW-1:0]        in_index,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic [OUTPUTS-1:0]   out_valid,
  input  logic [OUTPUTS-1:0]   out_ready,
  output logic [DATA_SIZE-1:0] out_data [OUTPUTS]
`ifdef DISPATCHER_COUNT_EN
  ,
  output logic [15:0]          out_count [OUTPUTS]
`endif
);

  logic [OUTPUTS-1:0]   full_q, full_d;
  logic [DATA_SIZE-1:0] data_q [OUTPUTS];
  logic [DATA_SIZE-1:0] data_d [OUTPUTS];
  logic [OUTPUTS-1:0]   deliver;
  logic                 accept;

  // Ready looks only at the indexed lane, never at in_valid or in_data.
  always_comb begin
    in_ready = !full_q[in_index] || out_ready[in_index];
  end

  always_comb begin
    accept  = in_valid && in_ready;
    deliver = full_q & out_ready;
  end

  // A load on the same edge as a delivery wins, keeping the lane full.
  always_comb begin
    full_d = full_q & ~deliver;
    data_d = data_q;
    if (accept) begin
      full_d[in_index] = 1'b1;
      data_d[in_index] = in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      for (int i = 0; i < OUTPUTS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    out_valid = full_q;
    for (int i = 0; i < OUTPUTS; i++) begin
      out_data[i] = full_q[i] ? data_q[i] : '0;
    end
  end

`ifdef DISPATCHER_COUNT_EN
  logic [15:0] cnt_q [OUTPUTS];
  logic [15:0] cnt_d [OUTPUTS];

  // Saturating counters: stick at 0xFFFF.
  always_comb begin
    for (int i = 0; i < OUTPUTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (deliver[i] && cnt_q[i] != 16'hFFFF) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    out_count = cnt_q;
  end
`endif

endmodule

// File: tb/tb_request_dispatcher.sv
// Scoreboard bench for request_dispatcher: per-lane expected-beat queues,
// directed plan scenarios plus random traffic.
module tb_request_dispatcher;

  localparam int N = 8;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_index = '0;
  logic [W-1:0] in_data = '0;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready = '0;
  logic [W-1:0] out_data [N];
`ifdef DISPATCHER_COUNT_EN
  logic [15:0]  out_count [N];
`endif

  int checks = 0;
  int failures = 0;

  bit [W-1:0] exp_q [N][$];
  int         exp_cnt [N];
  bit         ready_exp;
  bit         mon_en = 1'b0;

  request_dispatcher #(.OUTPUTS(N), .DATA_SIZE(W)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_index(in_index),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef DISPATCHER_COUNT_EN
    ,
    .out_count(out_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compare visible lane state with the model, then retire deliveries.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      ready_exp = (exp_q[in_index].size() == 0) || out_ready[in_index];
      chk("in_ready", in_ready, ready_exp);
      for (int i = 0; i < N; i++) begin
        bit has;
        has = exp_q[i].size() != 0;
        chk($sformatf("out_valid[%0d]", i), out_valid[i], has);
        chk($sformatf("out_data[%0d]", i), out_data[i], has ? exp_q[i][0] : 0);
`ifdef DISPATCHER_COUNT_EN
        chk($sformatf("out_count[%0d]", i), out_count[i], exp_cnt[i]);
`endif
        if (has && out_ready[i]) begin
          void'(exp_q[i].pop_front());
          if (exp_cnt[i] < 65535) exp_cnt[i]++;
        end
      end
    end
  end

  // One cycle of stimulus; the expected beat is queued once it is accepted.
  task automatic cycle(input bit v, input int idx, input int d, input int rdy);
    @(posedge clock);
    #1;
    in_valid  = v;
    in_index  = 3'(idx);
    in_data   = W'(d);
    out_ready = N'(rdy);
    @(negedge clock);
    #1;
    if (v && ready_exp) exp_q[idx].push_back(W'(d));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_out_data[%0d]", tag, i), out_data[i], 0);
`ifdef DISPATCHER_COUNT_EN
      chk($sformatf("%s_out_count[%0d]", tag, i), out_count[i], 0);
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    #2;
    check_cleared("reset");
    @(posedge clock);
    #3 reset = 1'b0;
    mon_en = 1'b1;

    // Single beat to lane 3, then backpressure holds it.
    cycle(1, 3, 'hA5, 0);
    cycle(0, 0, 0, 0);
    chk("plan1_valid", out_valid, 8'b0000_1000);
    repeat (5) cycle(1, 3, 'h5A, 0);
    cycle(1, 2, 'h77, 0);
    cycle(0, 0, 0, 0);
    chk("plan2_lane2", out_data[2], 'h77);
    chk("plan2_lane3", out_data[3], 'hA5);

    // Same-edge deliver and reload on lane 5.
    cycle(1, 5, 'h11, 0);
    cycle(1, 5, 'h22, 'h20);
    cycle(0, 0, 0, 0);
    chk("plan3_lane5", out_data[5], 'h22);

    // Drain and stream one beat per lane with all consumers ready.
    cycle(0, 0, 0, 'hFF);
    for (int i = 0; i < N; i++) cycle(1, i, 'h30 + i, 'hFF);
    cycle(0, 0, 0, 'hFF);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, N - 1),
            $urandom_range(0, 255), $urandom_range(0, 255));
    end

    // Asynchronous reset with lanes 1 and 6 full.
    cycle(0, 0, 0, 'hFF);
    cycle(1, 1, 'h61, 0);
    cycle(1, 6, 'h66, 0);
    @(posedge clock);
    #1 in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_cleared("midreset");
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      exp_cnt[i] = 0;
    end
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    check_cleared("postreset");

    for (int k = 0; k < 100; k++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, N - 1),
            $urandom_range(0, 255), $urandom_range(0, 255));
    end

`ifdef DISPATCHER_COUNT_EN
    // Saturation on lane 0.
    cycle(0, 0, 0, 'hFF);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    for (int k = 0; k < 70000; k++) cycle(1, 0, k & 'hFF, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("sat_count0", out_count[0], 'hFFFF);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
